// File: rtl/fp_pkg.sv
// Shared constants, state encoding and rounding-mode selection for fp_norm_round.
// Define FP_NORM_ROUND_RNE_EN for round-to-nearest-even; otherwise the result is truncated.
package fp_pkg;

   localparam int unsigned EXP_W   = 8;
   localparam int unsigned FRAC_W  = 23;
   localparam int unsigned EXP_MAX = 255;
   localparam int unsigned BIAS    = 127;
   localparam int unsigned MANT_W  = FRAC_W + 4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_ROUND = 2'd2,
      S_DONE  = 2'd3
   } state_t;

`ifdef FP_NORM_ROUND_RNE_EN
   localparam bit RNE_EN = 1'b1;
`else
   localparam bit RNE_EN = 1'b0;
`endif

endpackage

// File: rtl/fp_rne_rounder.sv
// Combinational fraction rounder; increments on guard & (sticky | lsb) when RNE is enabled.
module fp_rne_rounder
   import fp_pkg::*;
(
   input  logic [FRAC_W-1:0] frac,
   input  logic              guard,
   input  logic              sticky,
   output logic [FRAC_W-1:0] rounded,
   output logic              carry
);

   logic inc;

   always_comb begin
      inc              = RNE_EN & guard & (sticky | frac[0]);
      {carry, rounded} = {1'b0, frac} + (FRAC_W+1)'(inc);
   end

endmodule

// File: rtl/fp_norm_round.sv
// Normalise a raw {carry,hidden,frac,guard,sticky} sum and round it to IEEE-754 single.
// Rounding mode is selected by FP_NORM_ROUND_RNE_EN (see fp_pkg).
module fp_norm_round
   import fp_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_sign,
   input  logic [EXP_W-1:0]  in_exp,
   input  logic [MANT_W-1:0] in_mant,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_result,
   output logic              out_of,
   output logic              out_uf,
   output logic              out_zero
);

   state_t            state, state_n;
   logic              sign_r, sign_n;
   logic [EXP_W-1:0]  exp_r, exp_n;
   logic [MANT_W-1:0] mant_r, mant_n;
   logic              zero_r, zero_n, uf_r, uf_n, of_r, of_n;
   logic              valid_n;
   logic [31:0]       result_n;
   logic              out_of_n, out_uf_n, out_zero_n;

   logic [FRAC_W-1:0] rnd_frac;
   logic              rnd_carry;
   logic [EXP_W:0]    exp_sum;

   assign in_ready = (state == S_IDLE);

   fp_rne_rounder u_rounder (
      .frac    (mant_r[FRAC_W+1:2]),
      .guard   (mant_r[1]),
      .sticky  (mant_r[0]),
      .rounded (rnd_frac),
      .carry   (rnd_carry)
   );

   assign exp_sum = {1'b0, exp_r} + (EXP_W+1)'(rnd_carry);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         sign_r     <= 1'b0;
         exp_r      <= '0;
         mant_r     <= '0;
         zero_r     <= 1'b0;
         uf_r       <= 1'b0;
         of_r       <= 1'b0;
         out_valid  <= 1'b0;
         out_result <= '0;
         out_of     <= 1'b0;
         out_uf     <= 1'b0;
         out_zero   <= 1'b0;
      end else begin
         state      <= state_n;
         sign_r     <= sign_n;
         exp_r      <= exp_n;
         mant_r     <= mant_n;
         zero_r     <= zero_n;
         uf_r       <= uf_n;
         of_r       <= of_n;
         out_valid  <= valid_n;
         out_result <= result_n;
         out_of     <= out_of_n;
         out_uf     <= out_uf_n;
         out_zero   <= out_zero_n;
      end
   end

   always_comb begin
      state_n    = state;
      sign_n     = sign_r;
      exp_n      = exp_r;
      mant_n     = mant_r;
      zero_n     = zero_r;
      uf_n       = uf_r;
      of_n       = of_r;
      valid_n    = out_valid;
      result_n   = out_result;
      out_of_n   = out_of;
      out_uf_n   = out_uf;
      out_zero_n = out_zero;

      case (state)
         S_IDLE: begin
            if (in_valid) begin
               sign_n = in_sign;
               exp_n  = in_exp;
               mant_n = in_mant;
               zero_n = 1'b0;
               uf_n   = 1'b0;
               of_n   = 1'b0;
               if (in_mant == '0) begin
                  zero_n  = 1'b1;
                  sign_n  = 1'b0;
                  state_n = S_ROUND;
               end else if (in_mant[MANT_W-1]) begin
                  // Carry: shift right, the dropped bit folds into sticky.
                  mant_n  = {1'b0, in_mant[MANT_W-1:2], in_mant[1] | in_mant[0]};
                  exp_n   = in_exp + EXP_W'(1);
                  of_n    = (in_exp >= EXP_W'(EXP_MAX - 1));
                  state_n = S_ROUND;
               end else if (in_mant[MANT_W-2]) begin
                  state_n = S_ROUND;
               end else begin
                  state_n = S_SHIFT;
               end
            end
         end
         S_SHIFT: begin
            if (exp_r <= EXP_W'(1)) begin
               uf_n    = 1'b1;
               state_n = S_ROUND;
            end else begin
               // Guard moves into the fraction LSB, sticky stays put.
               mant_n = {mant_r[MANT_W-2:1], 1'b0, mant_r[0]};
               exp_n  = exp_r - EXP_W'(1);
               if (mant_r[MANT_W-3]) state_n = S_ROUND;
            end
         end
         S_ROUND: begin
            out_of_n   = 1'b0;
            out_uf_n   = 1'b0;
            out_zero_n = 1'b0;
            if (zero_r) begin
               result_n   = '0;
               out_zero_n = 1'b1;
            end else if (uf_r) begin
               result_n = {sign_r, 31'b0};
               out_uf_n = 1'b1;
            end else if (of_r || (exp_sum >= (EXP_W+1)'(EXP_MAX))) begin
               result_n = {sign_r, 8'hFF, 23'b0};
               out_of_n = 1'b1;
            end else begin
               result_n = {sign_r, exp_sum[EXP_W-1:0], rnd_frac};
            end
            valid_n = 1'b1;
            state_n = S_DONE;
         end
         S_DONE: begin
            if (out_ready) begin
               valid_n = 1'b0;
               state_n = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

endmodule
